// File: rtl/mem_model_q_drain_if.sv
// Queue read side and Avalon-MM-style write master bundled for the write-queue drain.
// The drain block connects through the master modport; the queue/slave side uses the slave modport.
interface mem_model_q_drain_if;
  logic        q_empty;
  logic [43:0] q_rdata;
  logic        q_read;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  modport master (
    input  q_empty, q_rdata, avm_waitrequest,
    output q_read, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output q_empty, q_rdata, avm_waitrequest,
    input  q_read, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/mem_model_q_drain.sv
// Drains the memory model's FWFT write queue: pops one {offset,data} entry at a time and
// issues it as a single bus write, with pause/enable, flush-and-report, inter-write gap and a write count.
//
// state   | meaning
// S_IDLE  | waiting for an entry (enable or flush) or reporting flush completion
// S_POP   | q_read high for one cycle, head entry already held
// S_ISSUE | avm_write high until the slave drops waitrequest
// S_GAP   | GAP idle cycles after an accepted write
module mem_model_q_drain #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GAP       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_i,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       busy_o,
  output logic [15:0]                tx_count_o,
  mem_model_q_drain_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_ISSUE, S_GAP} state_t;

  localparam logic [7:0] GAP_LOAD = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t      state_q, state_d;
  logic        flushing_q, flushing_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] tx_count_q, tx_count_d;
  logic        q_read_q, q_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        busy_q, busy_d;
  logic        flush_done_q, flush_done_d;
  logic        flush_eff;
  logic        accept;

  // A flush pulse takes effect in the same cycle it is sampled, not only once the flag is set.
  assign flush_eff = flushing_q | flush_i;
  assign accept    = avm_write_q & ~bus.avm_waitrequest;

  always_comb begin
    state_d      = state_q;
    flushing_d   = flush_eff;
    gap_cnt_d    = gap_cnt_q;
    tx_count_d   = tx_count_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    flush_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((enable_i | flush_eff) & ~bus.q_empty) begin
          state_d = S_POP;
          addr_d  = BASE_ADDR + {18'b0, bus.q_rdata[43:32], 2'b00};
          wdata_d = bus.q_rdata[31:0];
        end else if (flush_eff & bus.q_empty) begin
          flush_done_d = 1'b1;
          flushing_d   = 1'b0;
        end
      end
      S_POP: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          tx_count_d = tx_count_q + 16'd1;
          if (GAP != 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    q_read_d    = (state_d == S_POP);
    avm_write_d = (state_d == S_ISSUE);
    be_d        = avm_write_d ? 4'hF : 4'h0;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flushing_q   <= 1'b0;
      gap_cnt_q    <= 8'd0;
      tx_count_q   <= 16'd0;
      q_read_q     <= 1'b0;
      avm_write_q  <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'h0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flushing_q   <= flushing_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_count_q   <= tx_count_d;
      q_read_q     <= q_read_d;
      avm_write_q  <= avm_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.q_read         = q_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = be_q;
  assign busy_o             = busy_q;
  assign flush_done_o       = flush_done_q;
  assign tx_count_o         = tx_count_q;

endmodule

// File: tb/tb_mem_model_q_drain.sv
// Bench for mem_model_q_drain: a FWFT queue model feeds two instances (GAP=0 and GAP=4);
// expected writes are queued at push time and compared against writes the bus actually accepts.
module tb_mem_model_q_drain;

  localparam logic [31:0] BASE0 = 32'h1000_0000;
  localparam logic [31:0] BASE1 = 32'h2000_0000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable0 = 1'b0, flush0 = 1'b0;
  logic        enable1 = 1'b0, flush1 = 1'b0;
  logic        fd0, busy0, fd1, busy1;
  logic [15:0] cnt0, cnt1;

  mem_model_q_drain_if ifc0 ();
  mem_model_q_drain_if ifc1 ();

  mem_model_q_drain #(.BASE_ADDR(BASE0), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .enable_i(enable0), .flush_i(flush0),
    .flush_done_o(fd0), .busy_o(busy0), .tx_count_o(cnt0), .bus(ifc0)
  );

  mem_model_q_drain #(.BASE_ADDR(BASE1), .GAP(4)) dut1 (
    .clk(clk), .reset(reset), .enable_i(enable1), .flush_i(flush1),
    .flush_done_o(fd1), .busy_o(busy1), .tx_count_o(cnt1), .bus(ifc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int qr0 = 0, qr1 = 0, fdc0 = 0;

  logic [43:0] fifo0[$];
  logic [43:0] fifo1[$];
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  wr_t         obs0[$];
  wr_t         obs1[$];

  // Queue advances on the edge that ends a q_read cycle.
  always @(posedge clk) begin
    cyc++;
    if (ifc0.q_read && fifo0.size() > 0) void'(fifo0.pop_front());
    if (ifc1.q_read && fifo1.size() > 0) void'(fifo1.pop_front());
  end

  always @(negedge clk) begin
    if (ifc0.avm_write && !ifc0.avm_waitrequest)
      obs0.push_back('{a: ifc0.avm_address, d: ifc0.avm_writedata, c: cyc});
    if (ifc1.avm_write && !ifc1.avm_waitrequest)
      obs1.push_back('{a: ifc1.avm_address, d: ifc1.avm_writedata, c: cyc});
    if (ifc0.q_read) qr0++;
    if (ifc1.q_read) qr1++;
    if (fd0) fdc0++;
    ifc0.q_empty = (fifo0.size() == 0);
    ifc0.q_rdata = (fifo0.size() > 0) ? fifo0[0] : 44'd0;
    ifc1.q_empty = (fifo1.size() == 0);
    ifc1.q_rdata = (fifo1.size() > 0) ? fifo1[0] : 44'd0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push0(input logic [11:0] off, input logic [31:0] d);
    fifo0.push_back({off, d});
    exp0.push_back({BASE0 + {18'b0, off, 2'b00}, d});
  endtask

  task automatic push1(input logic [11:0] off, input logic [31:0] d);
    fifo1.push_back({off, d});
    exp1.push_back({BASE1 + {18'b0, off, 2'b00}, d});
  endtask

  task automatic wait_obs(input int which, input int n, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 ? obs0.size() : obs1.size()) >= n) break;
      @(negedge clk); #1;
    end
    ok = ((which == 0 ? obs0.size() : obs1.size()) >= n);
  endtask

  task automatic test_reset();
    bit ok;
    wr_t w;
    logic [63:0] e;
    reset = 1'b1;
    enable0 = 1'b1;
    push0(12'h001, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({ifc0.q_read, ifc0.avm_write, busy0, fd0, ifc0.avm_byteenable} !== 8'h00 ||
          ifc0.avm_address !== 32'd0 || ifc0.avm_writedata !== 32'd0 || cnt0 !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: q_read=%b write=%b busy=%b fd=%b be=%h addr=%h data=%h cnt=%h required all zero",
                 ifc0.q_read, ifc0.avm_write, busy0, fd0, ifc0.avm_byteenable, ifc0.avm_address, ifc0.avm_writedata, cnt0);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (ifc0.q_read !== 1'b0) begin n_fail++; $display("FAIL reset_release_early: q_read=%b required 0", ifc0.q_read); end
    @(negedge clk); #1;
    n_checks++;
    if (ifc0.q_read !== 1'b1) begin n_fail++; $display("FAIL reset_first_qread: q_read=%b required 1", ifc0.q_read); end
    wait_obs(0, 1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL reset_write_timeout: got 0 writes required 1");
    end else begin
      w = obs0.pop_front(); e = exp0.pop_front();
      if ({w.a, w.d} !== e) begin n_fail++; $display("FAIL reset_write: got %h/%h required %h", w.a, w.d, e); end
    end
  endtask

  task automatic test_two_writes();
    bit ok;
    wr_t w0, w1;
    logic [63:0] e0, e1;
    int qb;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    qb = qr0;
    push0(12'h004, 32'hDEAD_BEEF);
    push0(12'hFFF, 32'h1234_5678);
    wait_obs(0, 2, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL two_timeout: got %0d writes required 2", obs0.size());
    end else begin
      w0 = obs0.pop_front(); w1 = obs0.pop_front();
      e0 = exp0.pop_front(); e1 = exp0.pop_front();
      n_checks++;
      if ({w0.a, w0.d} !== e0) begin n_fail++; $display("FAIL two_first: got %h/%h required %h", w0.a, w0.d, e0); end
      n_checks++;
      if ({w1.a, w1.d} !== e1) begin n_fail++; $display("FAIL two_second: got %h/%h required %h", w1.a, w1.d, e1); end
      n_checks++;
      if (w1.c - w0.c !== 3) begin n_fail++; $display("FAIL two_spacing: got %0d cycles required 3", w1.c - w0.c); end
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (qr0 - qb !== 2) begin n_fail++; $display("FAIL two_qread_pulses: got %0d required 2", qr0 - qb); end
    n_checks++;
    if (cnt0 !== 16'd2) begin n_fail++; $display("FAIL two_tx_count: got %0d required 2", cnt0); end
  endtask

  task automatic test_waitrequest();
    bit ok;
    int qb, found;
    logic [15:0] cb;
    logic [63:0] e;
    wr_t w;
    cb = cnt0;
    ifc0.avm_waitrequest = 1'b1;
    push0(12'h010, 32'hCAFE_F00D);
    push0(12'h020, 32'h0BAD_F00D);
    e = exp0[0];
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ifc0.avm_write) begin found = 1; break; end
    end
    n_checks++;
    if (found == 0) begin n_fail++; $display("FAIL wait_issue_timeout: avm_write never rose"); end
    qb = qr0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_checks++;
      if (ifc0.avm_write !== 1'b1 || ifc0.avm_byteenable !== 4'hF || {ifc0.avm_address, ifc0.avm_writedata} !== e) begin
        n_fail++;
        $display("FAIL wait_stable_%0d: write=%b be=%h addr/data=%h/%h required 1/F/%h", i, ifc0.avm_write,
                 ifc0.avm_byteenable, ifc0.avm_address, ifc0.avm_writedata, e);
      end
    end
    @(posedge clk); #1 ifc0.avm_waitrequest = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (ifc0.avm_write !== 1'b1 || {ifc0.avm_address, ifc0.avm_writedata} !== e || qr0 !== qb || cnt0 !== cb) begin
      n_fail++;
      $display("FAIL wait_sixth: write=%b addr/data=%h/%h qreads=%0d cnt=%h required 1/%h/%0d/%h",
               ifc0.avm_write, ifc0.avm_address, ifc0.avm_writedata, qr0 - qb, cnt0, e, 0, cb);
    end
    @(negedge clk); #1;
    n_checks++;
    if (cnt0 !== cb + 16'd1) begin n_fail++; $display("FAIL wait_count_once: got %h required %h", cnt0, cb + 16'd1); end
    wait_obs(0, 2, 30, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL wait_drain_timeout: got %0d writes required 2", obs0.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        w = obs0.pop_front(); e = exp0.pop_front();
        n_checks++;
        if ({w.a, w.d} !== e) begin n_fail++; $display("FAIL wait_write_%0d: got %h/%h required %h", i, w.a, w.d, e); end
      end
    end
  endtask

  task automatic test_gap();
    bit ok;
    wr_t w[3];
    logic [63:0] e;
    enable1 = 1'b1;
    push1(12'h001, 32'h1111_0001);
    push1(12'h002, 32'h2222_0002);
    push1(12'h3FF, 32'h3333_0003);
    wait_obs(1, 1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL gap_first_timeout: no write seen"); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (busy1 !== 1'b1 || ifc1.avm_write !== 1'b0) begin
        n_fail++; $display("FAIL gap_cycle_%0d: busy=%b write=%b required 1/0", i, busy1, ifc1.avm_write);
      end
    end
    wait_obs(1, 3, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL gap_drain_timeout: got %0d writes required 3", obs1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        w[i] = obs1.pop_front(); e = exp1.pop_front();
        n_checks++;
        if ({w[i].a, w[i].d} !== e) begin n_fail++; $display("FAIL gap_write_%0d: got %h/%h required %h", i, w[i].a, w[i].d, e); end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (w[i].c - w[i-1].c !== 7) begin n_fail++; $display("FAIL gap_spacing_%0d: got %0d required 7", i, w[i].c - w[i-1].c); end
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    int qb, fb, found;
    wr_t w;
    logic [63:0] e;
    enable0 = 1'b0;
    qb = qr0;
    fb = fdc0;
    push0(12'h100, 32'hF100_0000);
    push0(12'h101, 32'hF100_0001);
    push0(12'h102, 32'hF100_0002);
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (obs0.size() != 0 || qr0 != qb || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL flush_disabled_hold: writes=%0d qreads=%0d busy=%b required 0/0/0", obs0.size(), qr0 - qb, busy0);
    end
    @(posedge clk); #1 flush0 = 1'b1;
    @(posedge clk); #1 flush0 = 1'b0;
    wait_obs(0, 3, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL flush_drain_timeout: got %0d writes required 3", obs0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        w = obs0.pop_front(); e = exp0.pop_front();
        n_checks++;
        if ({w.a, w.d} !== e) begin n_fail++; $display("FAIL flush_write_%0d: got %h/%h required %h", i, w.a, w.d, e); end
      end
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (fd0) begin found = 1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (found == 0) begin
      n_fail++; $display("FAIL flush_done_timeout: flush_done never pulsed");
    end else if (ifc0.q_empty !== 1'b1 || ifc0.q_read !== 1'b0 || ifc0.avm_write !== 1'b0) begin
      n_fail++; $display("FAIL flush_done_context: q_empty=%b q_read=%b write=%b required 1/0/0", ifc0.q_empty, ifc0.q_read, ifc0.avm_write);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (fdc0 - fb !== 1) begin n_fail++; $display("FAIL flush_done_once: got %0d pulses required 1", fdc0 - fb); end
    qb = qr0;
    @(posedge clk); #1 flush0 = 1'b1;
    @(posedge clk); #1 flush0 = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (fd0 !== 1'b1) begin n_fail++; $display("FAIL flush_empty_latency: flush_done=%b required 1", fd0); end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (obs0.size() != 0 || qr0 != qb || fdc0 - fb !== 2) begin
      n_fail++; $display("FAIL flush_empty_quiet: writes=%0d qreads=%0d pulses=%0d required 0/0/2", obs0.size(), qr0 - qb, fdc0 - fb);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    int qb, found;
    wr_t w;
    logic [63:0] e;
    @(negedge clk);
    force dut0.tx_count_q = 16'hFFFF;
    @(negedge clk);
    release dut0.tx_count_q;
    #1;
    n_checks++;
    if (cnt0 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h required FFFF", cnt0); end
    enable0 = 1'b1;
    push0(12'h0AA, 32'h5555_AAAA);
    wait_obs(0, 1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL wrap_timeout: no write seen");
    end else begin
      w = obs0.pop_front(); e = exp0.pop_front();
      if ({w.a, w.d} !== e) begin n_fail++; $display("FAIL wrap_write: got %h/%h required %h", w.a, w.d, e); end
    end
    @(negedge clk); #1;
    n_checks++;
    if (cnt0 !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h required 0000", cnt0); end

    ifc0.avm_waitrequest = 1'b1;
    push0(12'h0B0, 32'hDEAD_0001);
    push0(12'h0B1, 32'hBEEF_0002);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ifc0.avm_write) begin found = 1; break; end
    end
    n_checks++;
    if (found == 0) begin n_fail++; $display("FAIL rst_issue_timeout: avm_write never rose"); end
    reset = 1'b1;
    qb = qr0;
    @(negedge clk); #1;
    n_checks++;
    if (ifc0.avm_write !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_issue: write=%b busy=%b required 0/0", ifc0.avm_write, busy0);
    end
    repeat (3) @(negedge clk);
    #1;
    void'(exp0.pop_front());
    ifc0.avm_waitrequest = 1'b0;
    n_checks++;
    if (qr0 != qb || obs0.size() != 0) begin
      n_fail++; $display("FAIL rst_quiet: qreads=%0d writes=%0d required 0/0", qr0 - qb, obs0.size());
    end
    @(posedge clk); #1 reset = 1'b0;
    wait_obs(0, 1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_resume_timeout: no write after release");
    end else begin
      w = obs0.pop_front(); e = exp0.pop_front();
      if ({w.a, w.d} !== e) begin n_fail++; $display("FAIL rst_resume_write: got %h/%h required %h", w.a, w.d, e); end
    end
    @(negedge clk); #1;
    n_checks++;
    if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL rst_resume_count: got %h required 0001", cnt0); end
  endtask

  initial begin
    ifc0.q_empty = 1'b1; ifc0.q_rdata = 44'd0; ifc0.avm_waitrequest = 1'b0;
    ifc1.q_empty = 1'b1; ifc1.q_rdata = 44'd0; ifc1.avm_waitrequest = 1'b0;
    test_reset();
    test_two_writes();
    test_waitrequest();
    test_gap();
    test_flush();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
